// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and IF/ID latch operations.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic {RUN, REDIR_PEND} fetch_state_t;

    typedef enum logic [1:0] {IFID_HOLD, IFID_LOAD, IFID_BUBBLE} ifid_op_t;

    localparam word_t NOP_INSTR = '0;
endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module if_id_latch
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        i_op,
    input  logic [WORD_W-1:0] i_instr,
    input  logic [WORD_W-1:0] i_pc,
    input  logic [WORD_W-1:0] i_pcplus4,
    output logic [WORD_W-1:0] o_instr,
    output logic [WORD_W-1:0] o_pc,
    output logic [WORD_W-1:0] o_pcplus4,
    output logic              o_valid
);
    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_pcplus4;
    logic              r_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_instr   <= NOP_INSTR;
            r_pc      <= '0;
            r_pcplus4 <= '0;
            r_valid   <= 1'b0;
        end else begin
            case (i_op)
                IFID_LOAD: begin
                    r_instr   <= i_instr;
                    r_pc      <= i_pc;
                    r_pcplus4 <= i_pcplus4;
                    r_valid   <= 1'b1;
                end
                IFID_BUBBLE: begin
                    r_instr   <= NOP_INSTR;
                    r_pc      <= '0;
                    r_pcplus4 <= '0;
                    r_valid   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_instr   = r_instr;
    assign o_pc      = r_pc;
    assign o_pcplus4 = r_pcplus4;
    assign o_valid   = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, pending-redirect target and FSM, driving imem and the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              PC_write,
    input  logic              IFID_write,
    input  logic              flush,
    input  logic              hazard_detected,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt_wb,
    output logic [WORD_W-1:0] imemload_id,
    output logic [WORD_W-1:0] pc_id,
    output logic [WORD_W-1:0] pcplus4_id,
    output logic              valid_id
);
    fetch_state_t      r_state, w_state_nxt;
    logic [WORD_W-1:0] r_pc, w_pc_nxt;
    logic [WORD_W-1:0] r_tgt, w_tgt_nxt;
    logic              r_halted, w_halted_nxt;
    logic [1:0]        w_ifid_op;
    logic [WORD_W-1:0] w_pcplus4;
    logic [WORD_W-1:0] w_redir;

    assign w_pcplus4 = r_pc + WORD_W'(4);
    assign w_redir   = redirect_pc & ~WORD_W'(3);

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_tgt_nxt    = r_tgt;
        w_halted_nxt = r_halted;
        w_ifid_op    = IFID_HOLD;

        if (r_halted) begin
            w_ifid_op = IFID_HOLD;
        end else if (halt_wb) begin
            w_halted_nxt = 1'b1;
            w_ifid_op    = IFID_BUBBLE;
        end else if (r_state == REDIR_PEND) begin
            // The word returning now belongs to the abandoned path.
            w_ifid_op = IFID_BUBBLE;
            if (flush) w_tgt_nxt = w_redir;
            if (ihit) begin
                w_pc_nxt    = flush ? w_redir : r_tgt;
                w_state_nxt = RUN;
            end
        end else if (flush) begin
            w_ifid_op = IFID_BUBBLE;
            if (ihit) begin
                w_pc_nxt = w_redir;
            end else begin
                w_tgt_nxt   = w_redir;
                w_state_nxt = REDIR_PEND;
            end
        end else if (hazard_detected) begin
            w_ifid_op = IFID_HOLD;
        end else if (IFID_write) begin
            w_ifid_op = ihit ? IFID_LOAD : IFID_BUBBLE;
            if (ihit && PC_write) w_pc_nxt = w_pcplus4;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= RUN;
            r_pc     <= PC_INIT;
            r_tgt    <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_tgt    <= w_tgt_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    assign iREN     = ~r_halted;
    assign imemaddr = r_pc;

    if_id_latch #(.WORD_W(WORD_W)) u_if_id (
        .CLK      (CLK),
        .RST      (RST),
        .i_op     (w_ifid_op),
        .i_instr  (imemload),
        .i_pc     (r_pc),
        .i_pcplus4(w_pcplus4),
        .o_instr  (imemload_id),
        .o_pc     (pc_id),
        .o_pcplus4(pcplus4_id),
        .o_valid  (valid_id)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: linear steps with hand-computed expectations.
module tb_fetch_stage;
    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        PC_write;
    logic        IFID_write;
    logic        flush;
    logic        hazard_detected;
    logic [31:0] redirect_pc;
    logic        halt_wb;
    logic [31:0] imemload_id;
    logic [31:0] pc_id;
    logic [31:0] pcplus4_id;
    logic        valid_id;

    int n_assert = 0;
    int n_fail   = 0;

    fetch_stage #(.PC_INIT(32'h0), .WORD_W(32)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .ihit           (ihit),
        .imemload       (imemload),
        .iREN           (iREN),
        .imemaddr       (imemaddr),
        .PC_write       (PC_write),
        .IFID_write     (IFID_write),
        .flush          (flush),
        .hazard_detected(hazard_detected),
        .redirect_pc    (redirect_pc),
        .halt_wb        (halt_wb),
        .imemload_id    (imemload_id),
        .pc_id          (pc_id),
        .pcplus4_id     (pcplus4_id),
        .valid_id       (valid_id)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ins(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // imem returns ins(address) for whatever address is presented this cycle
    task automatic tick();
        imemload = ins(imemaddr);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; imemload = '0; PC_write = 1'b1; IFID_write = 1'b1;
        flush = 1'b0; hazard_detected = 1'b0; redirect_pc = '0; halt_wb = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("rst_addr",  imemaddr, 32'h0);
        chk("rst_iren",  {31'b0, iREN}, 32'h1);
        chk("rst_valid", {31'b0, valid_id}, 32'h0);
        chk("rst_instr", imemload_id, 32'h0);
        chk("rst_pc",    pc_id, 32'h0);
        chk("rst_pc4",   pcplus4_id, 32'h0);
        RST = 1'b0;

        // sequential fetch
        ihit = 1'b1;
        tick();
        chk("seq1_addr",  imemaddr, 32'h4);
        chk("seq1_valid", {31'b0, valid_id}, 32'h1);
        chk("seq1_instr", imemload_id, ins(32'h0));
        chk("seq1_pc",    pc_id, 32'h0);
        chk("seq1_pc4",   pcplus4_id, 32'h4);
        tick();
        chk("seq2_addr",  imemaddr, 32'h8);
        chk("seq2_pc",    pc_id, 32'h4);

        // load-use stall holds PC and IF/ID
        hazard_detected = 1'b1; PC_write = 1'b0; IFID_write = 1'b0;
        tick();
        chk("stall1_addr",  imemaddr, 32'h8);
        chk("stall1_instr", imemload_id, ins(32'h4));
        tick();
        chk("stall2_addr",  imemaddr, 32'h8);
        chk("stall2_instr", imemload_id, ins(32'h4));
        chk("stall2_valid", {31'b0, valid_id}, 32'h1);
        hazard_detected = 1'b0; PC_write = 1'b1; IFID_write = 1'b1;
        tick();
        chk("resume_addr",  imemaddr, 32'hC);
        chk("resume_instr", imemload_id, ins(32'h8));

        // flush with ihit; low address bits of the target are ignored
        flush = 1'b1; redirect_pc = 32'h43;
        tick();
        chk("fl_addr",  imemaddr, 32'h40);
        chk("fl_valid", {31'b0, valid_id}, 32'h0);
        chk("fl_instr", imemload_id, 32'h0);
        flush = 1'b0;
        tick();
        chk("fl_next_addr",  imemaddr, 32'h44);
        chk("fl_next_pc",    pc_id, 32'h40);
        chk("fl_next_valid", {31'b0, valid_id}, 32'h1);

        // flush while the fetch is still outstanding
        flush = 1'b1; ihit = 1'b0; redirect_pc = 32'h80;
        tick();
        chk("pend_addr",  imemaddr, 32'h44);
        chk("pend_valid", {31'b0, valid_id}, 32'h0);
        flush = 1'b0;
        tick();
        tick();
        chk("pend_wait_addr",  imemaddr, 32'h44);
        chk("pend_wait_valid", {31'b0, valid_id}, 32'h0);
        ihit = 1'b1;
        tick();
        chk("pend_done_addr",  imemaddr, 32'h80);
        chk("pend_done_valid", {31'b0, valid_id}, 32'h0);
        tick();
        chk("pend_after_pc",   pc_id, 32'h80);
        chk("pend_after_addr", imemaddr, 32'h84);

        // newer flush replaces the pending target
        flush = 1'b1; ihit = 1'b0; redirect_pc = 32'h80;
        tick();
        redirect_pc = 32'h90;
        tick();
        flush = 1'b0; ihit = 1'b1;
        tick();
        chk("newest_addr",  imemaddr, 32'h90);
        chk("newest_valid", {31'b0, valid_id}, 32'h0);

        // flush in the same cycle the pending fetch completes
        flush = 1'b1; ihit = 1'b0; redirect_pc = 32'hA0;
        tick();
        ihit = 1'b1; redirect_pc = 32'hB0;
        tick();
        chk("samecyc_addr", imemaddr, 32'hB0);
        flush = 1'b0;
        tick();
        chk("samecyc_pc", pc_id, 32'hB0);

        // PC wraps
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wrap_pre_addr", imemaddr, 32'hFFFF_FFFC);
        flush = 1'b0;
        tick();
        chk("wrap_pc",   pc_id, 32'hFFFF_FFFC);
        chk("wrap_pc4",  pcplus4_id, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);

        // halt beats flush, then everything freezes
        halt_wb = 1'b1; flush = 1'b1; redirect_pc = 32'h200;
        tick();
        chk("halt_iren",  {31'b0, iREN}, 32'h0);
        chk("halt_addr",  imemaddr, 32'h0);
        chk("halt_valid", {31'b0, valid_id}, 32'h0);
        halt_wb = 1'b0;
        tick();
        chk("halted_flush_addr", imemaddr, 32'h0);
        chk("halted_iren",       {31'b0, iREN}, 32'h0);
        flush = 1'b0;
        tick();
        chk("halted_ihit_addr",  imemaddr, 32'h0);
        chk("halted_ihit_valid", {31'b0, valid_id}, 32'h0);

        // async reset clears halt
        RST = 1'b1;
        #2;
        chk("unhalt_iren", {31'b0, iREN}, 32'h1);
        RST = 1'b0;
        tick();
        chk("unhalt_addr", imemaddr, 32'h4);

        // async reset while a redirect is pending
        flush = 1'b1; ihit = 1'b0; redirect_pc = 32'h100;
        tick();
        chk("rstpend_hold_addr", imemaddr, 32'h4);
        flush = 1'b0;
        RST = 1'b1;
        #2;
        chk("rstpend_addr",  imemaddr, 32'h0);
        chk("rstpend_valid", {31'b0, valid_id}, 32'h0);
        RST = 1'b0;
        ihit = 1'b1;
        tick();
        chk("rstpend_run_addr",  imemaddr, 32'h4);
        chk("rstpend_run_valid", {31'b0, valid_id}, 32'h1);
        chk("rstpend_run_pc",    pc_id, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
